// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory bus arbiter.
// Optional build macro used by the arbiter: ROM_PROTECT_EN.
package mem_arb_pkg;
   localparam int ADDR_W = 16;
   localparam int DATA_W = 8;
   localparam logic [3:0] ROM_TOP_NIBBLE_DFLT = 4'h0;

   typedef enum logic [2:0] {
      ST_IDLE        = 3'd0,
      ST_CPU_RD      = 3'd1,
      ST_CPU_RD_HOLD = 3'd2,
      ST_CPU_WR      = 3'd3,
      ST_HOST_RD     = 3'd4
   } arb_state_e;
endpackage

// File: rtl/mem_bus_arbiter_if.sv
// CPU strobe bus, host valid/ready port and block-RAM port bundled together.
// slave = arbiter side, master = environment (CPU, host, memory) side.
interface mem_bus_arbiter_if;
   import mem_arb_pkg::*;

   logic              cpu_nrds;
   logic              cpu_nwds;
   logic [ADDR_W-1:0] cpu_addr;
   logic [DATA_W-1:0] cpu_wdata;
   logic [DATA_W-1:0] cpu_rdata;
   logic              cpu_hold;
   logic              host_valid;
   logic              host_we;
   logic [ADDR_W-1:0] host_addr;
   logic [DATA_W-1:0] host_wdata;
   logic              host_ready;
   logic              host_rvalid;
   logic [DATA_W-1:0] host_rdata;
   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   modport slave (
      input  cpu_nrds, cpu_nwds, cpu_addr, cpu_wdata,
      input  host_valid, host_we, host_addr, host_wdata, mem_rdata,
      output cpu_rdata, cpu_hold, host_ready, host_rvalid, host_rdata,
      output mem_en, mem_we, mem_addr, mem_wdata
   );

   modport master (
      output cpu_nrds, cpu_nwds, cpu_addr, cpu_wdata,
      output host_valid, host_we, host_addr, host_wdata, mem_rdata,
      input  cpu_rdata, cpu_hold, host_ready, host_rvalid, host_rdata,
      input  mem_en, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/strobe_sync.sv
// 2-FF synchronizer for an asynchronous active-low strobe plus edge detect.
// Everything resets to 1 (strobe inactive) so reset release never fakes an edge.
module strobe_sync (
   input  logic clk,
   input  logic reset_n,
   input  logic strobe_n_i,
   output logic level_o,
   output logic fall_o,
   output logic rise_o
);
   logic meta_q, sync_q, prev_q;

   // synchronizer chain plus one delay stage for edge detection
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         meta_q <= 1'b1;
         sync_q <= 1'b1;
         prev_q <= 1'b1;
      end else begin
         meta_q <= strobe_n_i;
         sync_q <= meta_q;
         prev_q <= sync_q;
      end
   end

   assign level_o = sync_q;
   assign fall_o  = prev_q & ~sync_q;
   assign rise_o  = ~prev_q & sync_q;
endmodule

// File: rtl/mem_bus_arbiter.sv
// Arbitrates the single-port block RAM between the 8070 CPU strobes and the
// host loader port. CPU has fixed priority; a starvation counter raises
// cpu_hold when the host has waited HOST_MAX_WAIT cycles.
// Build macro ROM_PROTECT_EN: CPU writes into the ROM nibble are dropped.
module mem_bus_arbiter #(
   parameter int         ADDR_W         = mem_arb_pkg::ADDR_W,
   parameter int         DATA_W         = mem_arb_pkg::DATA_W,
   parameter int         HOST_MAX_WAIT  = 64,
   parameter logic [3:0] ROM_TOP_NIBBLE = mem_arb_pkg::ROM_TOP_NIBBLE_DFLT
) (
   input logic               clk,
   input logic               reset_n,
   mem_bus_arbiter_if.slave  bus
);
   import mem_arb_pkg::*;

`ifdef ROM_PROTECT_EN
   localparam logic ROM_PROT = 1'b1;
`else
   localparam logic ROM_PROT = 1'b0;
`endif
   localparam logic [7:0] WAIT_MAX = 8'(HOST_MAX_WAIT);

   arb_state_e        state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
   logic [DATA_W-1:0] host_rdata_q, host_rdata_d;
   logic              host_rvalid_q, host_rvalid_d;
   logic [7:0]        wait_q, wait_d;
   logic              hold_q, hold_d;

   logic              mem_en_c, mem_we_c, host_ready_c;
   logic [ADDR_W-1:0] mem_addr_c;
   logic [DATA_W-1:0] mem_wdata_c;
   logic              rd_lvl, rd_fall, rd_rise;
   logic              wr_lvl, wr_fall, wr_rise;
   logic              wr_blocked;

   strobe_sync u_rd_sync (
      .clk(clk), .reset_n(reset_n), .strobe_n_i(bus.cpu_nrds),
      .level_o(rd_lvl), .fall_o(rd_fall), .rise_o(rd_rise)
   );

   strobe_sync u_wr_sync (
      .clk(clk), .reset_n(reset_n), .strobe_n_i(bus.cpu_nwds),
      .level_o(wr_lvl), .fall_o(wr_fall), .rise_o(wr_rise)
   );

   assign wr_blocked = ROM_PROT && (addr_q[ADDR_W-1 -: 4] == ROM_TOP_NIBBLE);

   // next-state, memory port and host handshake; memory outputs are combinational
   always_comb begin
      state_d       = state_q;
      addr_d        = addr_q;
      wdata_d       = wdata_q;
      cpu_rdata_d   = cpu_rdata_q;
      host_rdata_d  = host_rdata_q;
      host_rvalid_d = 1'b0;
      wait_d        = wait_q;
      hold_d        = hold_q;
      mem_en_c      = 1'b0;
      mem_we_c      = 1'b0;
      mem_addr_c    = '0;
      mem_wdata_c   = '0;
      host_ready_c  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (rd_fall) begin
               addr_d     = bus.cpu_addr;
               mem_en_c   = 1'b1;
               mem_addr_c = bus.cpu_addr;
               state_d    = ST_CPU_RD;
            end else if (wr_fall) begin
               addr_d  = bus.cpu_addr;
               wdata_d = bus.cpu_wdata;
               state_d = ST_CPU_WR;
            end else if (bus.host_valid) begin
               host_ready_c = 1'b1;
               mem_en_c     = 1'b1;
               mem_we_c     = bus.host_we;
               mem_addr_c   = bus.host_addr;
               if (bus.host_we) mem_wdata_c = bus.host_wdata;
               else             state_d     = ST_HOST_RD;
            end
         end
         ST_CPU_RD: begin
            cpu_rdata_d = bus.mem_rdata;
            state_d     = ST_CPU_RD_HOLD;
         end
         ST_CPU_RD_HOLD: begin
            if (rd_lvl) state_d = ST_IDLE;
         end
         ST_CPU_WR: begin
            if (!wr_lvl) wdata_d = bus.cpu_wdata;
            if (wr_rise) begin
               mem_en_c    = !wr_blocked;
               mem_we_c    = !wr_blocked;
               mem_addr_c  = addr_q;
               mem_wdata_c = wdata_q;
               state_d     = ST_IDLE;
            end
         end
         ST_HOST_RD: begin
            host_rdata_d  = bus.mem_rdata;
            host_rvalid_d = 1'b1;
            state_d       = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      // an access in flight when reset lands is dropped, never half-issued
      if (!reset_n) begin
         mem_en_c     = 1'b0;
         mem_we_c     = 1'b0;
         mem_addr_c   = '0;
         mem_wdata_c  = '0;
         host_ready_c = 1'b0;
      end
      // starvation tracking: any handshake clears, stalls count up to the cap
      if (host_ready_c) begin
         wait_d = '0;
         hold_d = 1'b0;
      end else if (bus.host_valid && (wait_q != WAIT_MAX)) begin
         wait_d = wait_q + 8'd1;
         if (wait_d == WAIT_MAX) hold_d = 1'b1;
      end
   end

   // state and datapath registers
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q       <= ST_IDLE;
         addr_q        <= '0;
         wdata_q       <= '0;
         cpu_rdata_q   <= '0;
         host_rdata_q  <= '0;
         host_rvalid_q <= 1'b0;
         wait_q        <= '0;
         hold_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         addr_q        <= addr_d;
         wdata_q       <= wdata_d;
         cpu_rdata_q   <= cpu_rdata_d;
         host_rdata_q  <= host_rdata_d;
         host_rvalid_q <= host_rvalid_d;
         wait_q        <= wait_d;
         hold_q        <= hold_d;
      end
   end

   assign bus.cpu_rdata   = cpu_rdata_q;
   assign bus.cpu_hold    = hold_q;
   assign bus.host_ready  = host_ready_c;
   assign bus.host_rvalid = host_rvalid_q;
   assign bus.host_rdata  = host_rdata_q;
   assign bus.mem_en      = mem_en_c;
   assign bus.mem_we      = mem_we_c;
   assign bus.mem_addr    = mem_addr_c;
   assign bus.mem_wdata   = mem_wdata_c;

   logic unused_ok;
   assign unused_ok = rd_rise;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed + randomized bench for mem_bus_arbiter with a RAM model and a
// reference memory image tracked from transaction intent.
module tb_mem_bus_arbiter;
   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

`ifdef ROM_PROTECT_EN
   localparam bit ROM_PROT = 1'b1;
`else
   localparam bit ROM_PROT = 1'b0;
`endif

   mem_bus_arbiter_if bus();

   mem_bus_arbiter #(
      .ADDR_W(16), .DATA_W(8), .HOST_MAX_WAIT(64), .ROM_TOP_NIBBLE(4'h0)
   ) dut (
      .clk(clk), .reset_n(reset_n), .bus(bus)
   );

   // block RAM model: registered read, write on enable
   logic [7:0]  mem [0:65535];
   int unsigned en_cnt = 0;
   int unsigned we_cnt = 0;
   logic [15:0] last_wa;
   logic [7:0]  last_wd;
   always @(posedge clk) begin
      if (bus.mem_en) begin
         en_cnt <= en_cnt + 1;
         if (bus.mem_we) begin
            mem[bus.mem_addr] <= bus.mem_wdata;
            we_cnt  <= we_cnt + 1;
            last_wa <= bus.mem_addr;
            last_wd <= bus.mem_wdata;
         end else begin
            bus.mem_rdata <= mem[bus.mem_addr];
         end
      end
   end

   logic [7:0] ref_mem [0:65535];
   int total = 0;
   int bad   = 0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      total++;
      assert (act === exp) else begin
         bad++;
         $error("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic host_write(input logic [15:0] a, input logic [7:0] d, output int n);
      n = 0;
      bus.host_valid = 1'b1; bus.host_we = 1'b1; bus.host_addr = a; bus.host_wdata = d;
      #1;
      while (!bus.host_ready && n < 300) begin step(); n++; end
      chk("hw_ready_in_time", 32'(n < 300), 1);
      chk("hw_mem_we", {bus.mem_en, bus.mem_we}, 2'b11);
      chk("hw_mem_addr", bus.mem_addr, a);
      chk("hw_mem_wdata", bus.mem_wdata, d);
      step();
      bus.host_valid = 1'b0; bus.host_we = 1'b0;
      ref_mem[a] = d;
   endtask

   task automatic host_read(input logic [15:0] a, output logic [7:0] d, output int n);
      n = 0;
      bus.host_valid = 1'b1; bus.host_we = 1'b0; bus.host_addr = a;
      #1;
      while (!bus.host_ready && n < 300) begin step(); n++; end
      chk("hr_ready_in_time", 32'(n < 300), 1);
      step();
      bus.host_valid = 1'b0;
      chk("hr_rvalid_early", bus.host_rvalid, 0);
      step();
      chk("hr_rvalid", bus.host_rvalid, 1);
      d = bus.host_rdata;
      step();
      chk("hr_rvalid_pulse", bus.host_rvalid, 0);
   endtask

   task automatic cpu_read(input logic [15:0] a, input int low, output logic [7:0] d);
      int unsigned e0;
      e0 = en_cnt;
      bus.cpu_addr = a; bus.cpu_nrds = 1'b0;
      repeat (4) step();
      d = bus.cpu_rdata;
      repeat (low - 4) step();
      bus.cpu_nrds = 1'b1;
      repeat (3) step();
      chk("cr_mem_en_once", en_cnt - e0, 1);
   endtask

   task automatic cpu_write(input logic [15:0] a, input logic [7:0] d1, input logic [7:0] d2,
                            input int low);
      int unsigned w0;
      logic        lands;
      w0 = we_cnt;
      lands = !(ROM_PROT && a[15:12] == 4'h0);
      bus.cpu_addr = a; bus.cpu_wdata = d1; bus.cpu_nwds = 1'b0;
      repeat (low / 2) step();
      bus.cpu_wdata = d2;
      repeat (low - low / 2) step();
      bus.cpu_nwds = 1'b1;
      repeat (3) step();
      chk("cw_we_count", we_cnt - w0, 32'(lands));
      if (lands) begin
         chk("cw_addr", last_wa, a);
         chk("cw_data", last_wd, d2);
         ref_mem[a] = d2;
      end
   endtask

   initial begin
      logic [7:0]  d;
      int          n;
      int unsigned w0;
      logic [15:0] pool [16];

      bus.cpu_nrds = 1'b1; bus.cpu_nwds = 1'b1; bus.cpu_addr = '0; bus.cpu_wdata = '0;
      bus.host_valid = 1'b1; bus.host_we = 1'b1; bus.host_addr = 16'h1111; bus.host_wdata = 8'h33;
      reset_n = 1'b0;
      repeat (3) step();
      // reset values, with a host request pending that must not be accepted
      chk("rst_host_ready", bus.host_ready, 0);
      chk("rst_mem_en", bus.mem_en, 0);
      chk("rst_mem_we", bus.mem_we, 0);
      chk("rst_mem_addr", bus.mem_addr, 0);
      chk("rst_mem_wdata", bus.mem_wdata, 0);
      chk("rst_cpu_rdata", bus.cpu_rdata, 0);
      chk("rst_cpu_hold", bus.cpu_hold, 0);
      chk("rst_host_rvalid", bus.host_rvalid, 0);
      chk("rst_host_rdata", bus.host_rdata, 0);
      bus.host_valid = 1'b0; bus.host_we = 1'b0;
      reset_n = 1'b1;
      step();

      // CPU read of a preloaded byte, 8 clk strobe
      host_write(16'h1234, 8'hA5, n);
      chk("hw_uncontended_wait", n, 0);
      cpu_read(16'h1234, 8, d);
      chk("cpu_read_1234", d, 8'hA5);
      host_read(16'h1234, d, n);
      chk("idle_after_cpu_read", n, 0);
      chk("host_read_1234", d, 8'hA5);

      // CPU write with data changing mid-strobe
      cpu_write(16'h2000, 8'h11, 8'h22, 8);
      host_read(16'h2000, d, n);
      chk("host_read_2000", d, 8'h22);

      // host write collides with the CPU read fall edge
      bus.cpu_addr = 16'h2000; bus.cpu_nrds = 1'b0;
      step(); step();
      bus.host_valid = 1'b1; bus.host_we = 1'b1; bus.host_addr = 16'h3000; bus.host_wdata = 8'h5A;
      #1;
      chk("coll_host_ready", bus.host_ready, 0);
      chk("coll_cpu_issue", {bus.mem_en, bus.mem_we}, 2'b10);
      chk("coll_cpu_addr", bus.mem_addr, 16'h2000);
      step();
      chk("coll_ready_rd", bus.host_ready, 0);
      step();
      chk("coll_cpu_rdata", bus.cpu_rdata, 8'h22);
      step(); step();
      bus.cpu_nrds = 1'b1;
      n = 0;
      while (!bus.host_ready && n < 10) begin step(); n++; end
      chk("coll_host_after_cpu", n, 3);
      chk("coll_host_we", {bus.mem_en, bus.mem_we}, 2'b11);
      step();
      bus.host_valid = 1'b0; bus.host_we = 1'b0;
      ref_mem[16'h3000] = 8'h5A;
      host_read(16'h3000, d, n);
      chk("coll_host_read", d, ref_mem[16'h3000]);

      // starvation: NRDS low 100 clk while host read waits
      bus.cpu_addr = 16'h3000; bus.cpu_nrds = 1'b0;
      step(); step();
      bus.host_valid = 1'b1; bus.host_we = 1'b0; bus.host_addr = 16'h3000;
      #1;
      chk("starve_hold_start", bus.cpu_hold, 0);
      repeat (63) step();
      chk("starve_hold_63", bus.cpu_hold, 0);
      step();
      chk("starve_hold_64", bus.cpu_hold, 1);
      repeat (34) step();
      chk("starve_hold_sat", bus.cpu_hold, 1);
      chk("starve_cpu_rdata", bus.cpu_rdata, 8'h5A);
      bus.cpu_nrds = 1'b1;
      n = 0;
      while (!bus.host_ready && n < 10) begin step(); n++; end
      chk("starve_host_served", n, 3);
      chk("starve_hold_at_hs", bus.cpu_hold, 1);
      step();
      bus.host_valid = 1'b0;
      chk("starve_hold_clear", bus.cpu_hold, 0);
      step();
      chk("starve_rvalid", bus.host_rvalid, 1);
      chk("starve_rdata", bus.host_rdata, 8'h5A);
      step();

      // ROM region: CPU write blocked only when protection is built in
      host_write(16'h0F00, 8'h00, n);
      cpu_write(16'h0F00, 8'h77, 8'h77, 6);
      host_read(16'h0F00, d, n);
      chk("rom_cpu_write_effect", d, ref_mem[16'h0F00]);
      w0 = we_cnt;
      host_write(16'h0F00, 8'h77, n);
      chk("rom_host_write_count", we_cnt - w0, 1);

      // reset during CPU_WR abandons the write
      host_write(16'h4000, 8'h10, n);
      w0 = we_cnt;
      bus.cpu_addr = 16'h4000; bus.cpu_wdata = 8'h99; bus.cpu_nwds = 1'b0;
      repeat (5) step();
      reset_n = 1'b0;
      bus.cpu_nwds = 1'b1;
      step();
      chk("rstwr_cpu_rdata", bus.cpu_rdata, 0);
      chk("rstwr_host_rdata", bus.host_rdata, 0);
      chk("rstwr_mem_en", bus.mem_en, 0);
      chk("rstwr_mem_we", bus.mem_we, 0);
      step(); step();
      chk("rstwr_mem_we_hold", bus.mem_we, 0);
      reset_n = 1'b1;
      step(); step();
      chk("rstwr_no_write", we_cnt - w0, 0);
      host_read(16'h4000, d, n);
      chk("rstwr_mem_intact", d, 8'h10);

      // randomized mix against the reference image
      for (int i = 0; i < 8; i++) begin
         pool[i]     = 16'h5000 + 16'(i);
         pool[i + 8] = 16'(i * 17);
      end
      for (int i = 0; i < 16; i++) host_write(pool[i], 8'($urandom), n);
      for (int i = 0; i < 40; i++) begin
         logic [15:0] a;
         a = pool[$urandom_range(0, 15)];
         case ($urandom_range(0, 3))
            0: begin
               cpu_read(a, 32'($urandom_range(4, 10)), d);
               chk("rnd_cpu_read", d, ref_mem[a]);
            end
            1: cpu_write(a, 8'($urandom), 8'($urandom), 32'($urandom_range(3, 10)));
            2: host_write(a, 8'($urandom), n);
            default: begin
               host_read(a, d, n);
               chk("rnd_host_read", d, ref_mem[a]);
            end
         endcase
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares the single-port 64 KB block-RAM memory between two requesters:
  - the 8070 CPU bus, via asynchronous NRDS/NWDS strobes;
  - a host loader/monitor port, via valid/ready, driven by the UART command parser.
- Runs in the sys_clk domain and sequences every memory access.
- CPU has fixed priority. A starvation counter holds the CPU off when the host has waited too long.

Parameters:
- ADDR_W, 16, memory address width.
- DATA_W, 8, memory data width.
- HOST_MAX_WAIT, 64, host-stall cycles before cpu_hold asserts (range 1..255).
- ROM_TOP_NIBBLE, 4'h0, value of addr[15:12] that marks the ROM region.

Ports:
- clk  in  1  system clock (27 MHz).
- reset_n  in  1  synchronous, active-low reset.
- cpu_nrds  in  1  CPU read strobe, asynchronous, active-low.
- cpu_nwds  in  1  CPU write strobe, asynchronous, active-low.
- cpu_addr  in  16  CPU address bus.
- cpu_wdata  in  8  CPU data bus, input side.
- cpu_rdata  out  8  registered read data for the CPU data bus.
- cpu_hold  out  1  request to stall the CPU.
- host_valid  in  1  host request valid.
- host_we  in  1  1 = write, 0 = read.
- host_addr  in  16  host address.
- host_wdata  in  8  host write data.
- host_ready  out  1  host request accepted this cycle.
- host_rvalid  out  1  one-cycle pulse: host_rdata valid.
- host_rdata  out  8  host read data.
- mem_en  out  1  memory access enable.
- mem_we  out  1  memory write enable.
- mem_addr  out  16  memory address.
- mem_wdata  out  8  memory write data.
- mem_rdata  in  8  memory read data, valid 1 cycle after mem_en.

Behaviour:
- Reset, synchronous on reset_n=0:
  - state goes to IDLE; synchronizers are set to 1;
  - cpu_rdata=0, cpu_hold=0, host_ready=0, host_rvalid=0, host_rdata=0;
  - mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - Reset mid-access abandons the access; no write is issued.
- Strobe handling:
  - Each strobe passes through a 2-FF synchronizer plus an edge detector.
  - Outputs: rd_fall, wr_fall, wr_rise.
- States: IDLE, CPU_RD, CPU_RD_HOLD, CPU_WR, HOST_RD.
- IDLE:
  - rd_fall: latch cpu_addr, issue mem_en=1, mem_we=0, go to CPU_RD.
  - else wr_fall: latch cpu_addr, go to CPU_WR.
  - else host_valid: host_ready=1 (combinational in IDLE when no CPU fall edge).
    - write: mem_en=1, mem_we=1 with host addr/data in the same cycle; stay in IDLE.
    - read: mem_en=1; go to HOST_RD.
  - CPU fall edge and host_valid in the same cycle: CPU wins, host_ready=0.
- CPU_RD: cpu_rdata <= mem_rdata; go to CPU_RD_HOLD.
- CPU_RD_HOLD: wait until the synchronized NRDS is high, then go to IDLE. cpu_rdata is held until the next CPU read completes.
- CPU_WR:
  - Capture cpu_wdata every cycle while synchronized NWDS is low.
  - On wr_rise: issue mem_en=1, mem_we=1 with the latched addr and the last captured data; go to IDLE.
- HOST_RD: host_rdata <= mem_rdata, host_rvalid=1 for one cycle; go to IDLE.
- Latency:
  - CPU read: cpu_rdata valid 4 clk after NRDS falls (2 sync + 1 issue + 1 capture).
  - Host read: host_rvalid 1 cycle after the handshake.
  - Host write: 0 wait cycles when uncontended.
- Outside access cycles: mem_en=0, mem_we=0.
- Starvation counter (8 bit):
  - Increments each cycle host_valid=1 and host_ready=0; saturates at HOST_MAX_WAIT.
  - Reaching HOST_MAX_WAIT sets cpu_hold=1.
  - Any host handshake clears both the counter and cpu_hold.
  - cpu_hold does not abort a CPU access already in progress.
- Strobe overlap: a fall edge on the other strobe during CPU_RD/CPU_RD_HOLD/CPU_WR is ignored.

Optional Feature:
- Macro: ROM_PROTECT_EN.
- Defined: a CPU write whose latched addr[15:12]==ROM_TOP_NIBBLE completes the CPU_WR sequence but issues no mem_en/mem_we. Host writes are always permitted, so the loader can program ROM.
- Undefined: all writes reach memory.

Decomposition:
- Package mem_arb_pkg:
  - state enum (3-bit encoding);
  - ROM_TOP_NIBBLE default;
  - ADDR_W and DATA_W constants.
- One sub-module, strobe_sync: 2-FF synchronizer plus rise/fall detector, instantiated twice (NRDS, NWDS).

Test Plan:
- Preload mem[0x1234]=0xA5; pulse NRDS low for 8 clk with cpu_addr=0x1234 -> mem_en once, cpu_rdata=0xA5 at clk 4 after the fall, state returns to IDLE after NRDS rises.
- NWDS low for 8 clk, addr=0x2000, data changes 0x11 to 0x22 midway -> exactly one mem_we, on wr_rise, writing 0x22 to 0x2000.
- host_valid write 0x3000=0x5A in the same cycle NRDS falls -> host_ready=0 that cycle; host accepted after the CPU read completes; a host read of 0x3000 then returns host_rvalid with 0x5A.
- Hold NRDS low for 100 clk with host_valid=1, HOST_MAX_WAIT=64 -> cpu_hold=1 at stall cycle 64; it clears the cycle the host handshake completes.
- With ROM_PROTECT_EN: CPU write 0x0F00=0x77 -> no mem_we; host write 0x0F00=0x77 -> mem_we=1.
- Assert reset_n=0 during CPU_WR -> no mem_we; all outputs at reset values the next cycle.
